// File: rtl/serial_alu.sv
// Bit-serial ALU: ADD/SUB run LSB-first through one full-adder slice, shifts move
// the word one position per cycle. start/busy/done handshake, registered flags.
module serial_alu #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             arith,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             V,
    output logic             Z
);
    // state  | meaning
    // IDLE   | waiting for start; the done pulse is shown here
    // ADDSUB | one result bit per cycle, LSB first, WIDTH cycles
    // SHIFT  | one position per cycle, shamt cycles (one pass-through cycle when 0)

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ADDSUB, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, y_q;
    logic [CW-1:0]    cnt_q;
    logic             op0_q, arith_q, carry_q;
    logic             done_q, c_q, v_q, z_q;
    logic             last;
    logic             bop, sum, cout, fill, sh_out;
    logic [WIDTH-1:0] add_res, sh_res;

    always_comb begin
        bop     = b_q[0] ^ op0_q;
        sum     = a_q[0] ^ bop ^ carry_q;
        cout    = (a_q[0] & bop) | (carry_q & (a_q[0] ^ bop));
        add_res = {sum, res_q[WIDTH-1:1]};
        // for arithmetic right shifts the MSB of the working word stays the sign bit
        fill    = arith_q & res_q[WIDTH-1];
        sh_res  = op0_q ? {res_q[WIDTH-2:0], 1'b0} : {fill, res_q[WIDTH-1:1]};
        sh_out  = op0_q ? res_q[WIDTH-1] : res_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = mode[1] ? SHIFT : ADDSUB;
            end
            ADDSUB: begin
                last = (cnt_q == CW'(1));
                if (last) state_d = IDLE;
            end
            SHIFT: begin
                last = (cnt_q <= CW'(1));
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op0_q   <= 1'b0;
            arith_q <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        op0_q   <= mode[0];
                        arith_q <= arith;
                        carry_q <= mode[0];
                        res_q   <= mode[1] ? A : '0;
                        cnt_q   <= mode[1] ? CW'(shamt) : CW'(WIDTH);
                    end
                end
                ADDSUB: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= cout;
                    res_q   <= add_res;
                    cnt_q   <= cnt_q - CW'(1);
                    if (last) begin
                        y_q    <= add_res;
                        c_q    <= cout;
                        v_q    <= carry_q ^ cout;
                        z_q    <= (add_res == '0);
                        done_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        y_q    <= res_q;
                        c_q    <= 1'b0;
                        v_q    <= 1'b0;
                        z_q    <= (res_q == '0);
                        done_q <= 1'b1;
                    end else begin
                        res_q <= sh_res;
                        cnt_q <= cnt_q - CW'(1);
                        if (last) begin
                            y_q    <= sh_res;
                            c_q    <= sh_out;
                            v_q    <= 1'b0;
                            z_q    <= (sh_res == '0);
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign Y    = y_q;
    assign C    = c_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule
